noc_flit_rx_buffer: RTL and testbench
=====================================

# noc_flit_rx_buffer

Credit-based flit receive buffer that terminates one router output port of the NoC and presents its flits as a valid/ready stream. It sits directly downstream of a ring router's ejection port (send/data/dest/is_tail, credit return), ahead of the deserializer shim. It stores up to FLIT_BUFFER_DEPTH flits, returns one credit per flit consumed, and can hold flits until a whole packet has arrived (store-and-forward).

## Interface
- FLIT_WIDTH, 128: flit payload width in bits.
- DEST_WIDTH, 6: routed destination width ({tid, tdest}).
- FLIT_BUFFER_DEPTH, 4: flit slots; power of two, ≥2; equals the sender's initial credit count.
- STORE_AND_FORWARD, 0: 1 = release flits only once a tail flit is buffered.
- clk  in  1  NoC clock; the block has one clock.
- rst  in  1  synchronous, active-high reset.
- data_in  in  FLIT_WIDTH  flit payload from router.
- dest_in  in  DEST_WIDTH  flit destination.
- is_tail_in  in  1  flit is last of packet.
- send_in  in  1  flit valid, one cycle per flit; no backpressure.
- credit_out  out  1  one-cycle pulse per freed slot.
- out_valid  out  1  flit available.
- out_ready  in  1  consumer accepts.
- out_data  out  FLIT_WIDTH  head flit payload.
- out_dest  out  DEST_WIDTH  head flit destination.
- out_is_tail  out  1  head flit tail marker.
- occupancy  out  $clog2(FLIT_BUFFER_DEPTH)+1  flits held.
- err_overflow  out  1  sticky overflow flag (see Configuration).

## Operation
- Push: send_in=1 writes {data_in, dest_in, is_tail_in} at the write pointer. The write pointer and count advance.
- Pop: out_valid && out_ready. The read pointer advances and the count decrements. credit_out pulses exactly one cycle later.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. The count range is 0..DEPTH.
- Simultaneous push and pop leave the count unchanged. At count==DEPTH, push and pop in the same cycle is legal: the slot being read is freed in that same cycle.
- Packet counter pkt_cnt, range 0..DEPTH:
  - increments on a push with is_tail_in=1;
  - decrements on a pop with out_is_tail=1;
  - both in the same cycle leave it unchanged.
- out_valid rules:
  - STORE_AND_FORWARD=0: out_valid = count≠0.
  - STORE_AND_FORWARD=1: out_valid = count≠0 && (pkt_cnt≠0 || count==DEPTH). The count==DEPTH term is a cut-through fallback that prevents deadlock on packets longer than DEPTH.
- out_data, out_dest and out_is_tail are held stable while out_valid && !out_ready.
- A push when count==DEPTH with no pop in the same cycle is a credit-protocol violation. The flit is dropped and no pointer moves.
- Reset mid-operation discards all buffered flits. No credits are returned for the discarded flits, because the upstream credit counter resets together with this block.

## Timing
- Reset values: credit_out=0, out_valid=0, occupancy=0, err_overflow=0. Pointers, count and pkt_cnt are 0. out_data, out_dest and out_is_tail are don't-care.
- Push to out_valid latency: 1 cycle. A flit pushed at edge N is visible after edge N; the consumer can pop it at edge N+1.
- Store-and-forward: out_valid rises 1 cycle after the tail push.
- Pop to credit_out: credit_out is registered and high for the cycle following the pop edge.
- Sustained throughput: 1 flit/cycle. Round-trip credit loop is 2 cycles plus router latency.
- occupancy is registered and equals the count.

## Configuration
- NOC_FLIT_RX_OVERFLOW_CHECK_EN defined:
  - err_overflow sets on a push while full without a simultaneous pop;
  - it stays set until rst;
  - simulation also issues $error on that event.
- Macro undefined: err_overflow is tied to 0 and no check logic is built. The drop behaviour is unchanged.

## Structure
- Shared package noc_pkg: flit struct typedef (data, dest, is_tail), parameterised via FLIT_WIDTH/DEST_WIDTH localparams; credit-pulse width constant.
- Sub-module noc_flit_fifo: storage array plus pointers, 1R1W, with a FORCE_MLAB-style attribute hook.
- Top level holds the count, pkt_cnt, the credit register, the release logic and the overflow check.

## Test plan
- Single flit: push A (is_tail=1), out_ready=1 → out_valid=1 from next cycle; one pop; credit_out pulses one cycle later; occupancy returns 0.
- Fill to 4 with out_ready=0 → occupancy=4, out_valid=1, out_data=first flit held; release → flits in order, 4 credit pulses on consecutive cycles.
- Full with simultaneous push and pop for 8 cycles → occupancy stays 4, 8 credits, no err_overflow, order preserved.
- STORE_AND_FORWARD=1:
  - 3-flit packet (tail last) → out_valid=0 until the cycle after the tail push;
  - 6-flit packet → out_valid asserts at occupancy 4 (fallback).
- With the macro defined: 5th push while full, no pop → flit dropped, err_overflow=1 persists until rst.
- Reset asserted with 3 flits buffered → next cycle: out_valid=0, occupancy=0, no credit_out pulse.

Source files
------------

// File: rtl/noc_flit_rx_buffer_pkg.sv
// Shared NoC types for the flit receive path: flit layout and credit constants.
package noc_pkg;

  localparam int unsigned FLIT_WIDTH          = 128;
  localparam int unsigned DEST_WIDTH          = 6;
  localparam int unsigned CREDIT_PULSE_CYCLES = 1;

  typedef struct packed {
    logic [FLIT_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic                  is_tail;
  } flit_t;

  // Width of one stored flit {data, dest, is_tail} for arbitrary widths.
  function automatic int unsigned flit_bits(input int unsigned fw, input int unsigned dw);
    return fw + dw + 1;
  endfunction

endpackage

// File: rtl/noc_flit_rx_buffer_if.sv
// Router-ejection ingress plus valid/ready egress of the flit receive buffer.
interface noc_flit_rx_buffer_if #(
  parameter int unsigned FLIT_WIDTH        = 128,
  parameter int unsigned DEST_WIDTH        = 6,
  parameter int unsigned FLIT_BUFFER_DEPTH = 4
);

  logic [FLIT_WIDTH-1:0]                data_in;
  logic [DEST_WIDTH-1:0]                dest_in;
  logic                                 is_tail_in;
  logic                                 send_in;
  logic                                 credit_out;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [FLIT_WIDTH-1:0]                out_data;
  logic [DEST_WIDTH-1:0]                out_dest;
  logic                                 out_is_tail;
  logic [$clog2(FLIT_BUFFER_DEPTH):0]   occupancy;
  logic                                 err_overflow;

  modport slave (
    input  data_in, dest_in, is_tail_in, send_in, out_ready,
    output credit_out, out_valid, out_data, out_dest, out_is_tail, occupancy, err_overflow
  );

  modport master (
    output data_in, dest_in, is_tail_in, send_in, out_ready,
    input  credit_out, out_valid, out_data, out_dest, out_is_tail, occupancy, err_overflow
  );

endinterface

// File: rtl/noc_flit_rx_buffer_fifo.sv
// noc_flit_fifo: 1R1W flit storage with wrapping pointers; read port is the
// combinational head slot. Occupancy tracking lives in the parent.
module noc_flit_fifo #(
  parameter int unsigned WIDTH = 135,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data
);

  localparam int unsigned PW = $clog2(DEPTH);

  (* ramstyle = "MLAB, no_rw_check" *) logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/noc_flit_rx_buffer.sv
// Credit-based flit receive buffer with optional store-and-forward release.
// Optional sticky overflow detection: define NOC_FLIT_RX_OVERFLOW_CHECK_EN.
module noc_flit_rx_buffer #(
  parameter int unsigned FLIT_WIDTH        = 128,
  parameter int unsigned DEST_WIDTH        = 6,
  parameter int unsigned FLIT_BUFFER_DEPTH = 4,
  parameter bit          STORE_AND_FORWARD = 1'b0
) (
  input logic                 clk,
  input logic                 rst,
  noc_flit_rx_buffer_if.slave bus
);

  import noc_pkg::flit_bits;

  localparam int unsigned   VW   = flit_bits(FLIT_WIDTH, DEST_WIDTH);
  localparam int unsigned   CW   = $clog2(FLIT_BUFFER_DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(FLIT_BUFFER_DEPTH);

  logic [CW-1:0] count;
  logic [CW-1:0] pkt_cnt;
  logic          credit_q;
  logic          full;
  logic          valid;
  logic          pop;
  logic          push;
  logic [VW-1:0] wr_vec;
  logic [VW-1:0] rd_vec;

  assign full = (count == FULL);
  assign pop  = valid && bus.out_ready;
  // A full buffer still accepts when the head leaves in the same cycle.
  assign push = bus.send_in && (!full || pop);

  generate
    if (STORE_AND_FORWARD) begin : g_saf
      assign valid = (count != '0) && ((pkt_cnt != '0) || full);
    end else begin : g_cut
      assign valid = (count != '0);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      pkt_cnt  <= '0;
      credit_q <= 1'b0;
    end else begin
      credit_q <= pop;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      case ({push && bus.is_tail_in, pop && bus.out_is_tail})
        2'b10:   pkt_cnt <= pkt_cnt + CW'(1);
        2'b01:   pkt_cnt <= pkt_cnt - CW'(1);
        default: ;
      endcase
    end
  end

  assign wr_vec = {bus.data_in, bus.dest_in, bus.is_tail_in};

  noc_flit_fifo #(
    .WIDTH (VW),
    .DEPTH (FLIT_BUFFER_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (wr_vec),
    .rd_en   (pop),
    .rd_data (rd_vec)
  );

  assign {bus.out_data, bus.out_dest, bus.out_is_tail} = rd_vec;
  assign bus.out_valid  = valid;
  assign bus.credit_out = credit_q;
  assign bus.occupancy  = count;

`ifdef NOC_FLIT_RX_OVERFLOW_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (bus.send_in && full && !pop) begin
      err_q <= 1'b1;
      $error("noc_flit_rx_buffer: flit received while full, dropped");
    end
  end

  assign bus.err_overflow = err_q;
`else
  assign bus.err_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_noc_flit_rx_buffer.sv
// Scoreboard bench: cut-through instance (ia) and store-and-forward instance (ib).
module tb_noc_flit_rx_buffer;
  import noc_pkg::*;

  localparam logic EXP_ERR =
`ifdef NOC_FLIT_RX_OVERFLOW_CHECK_EN
    1'b1;
`else
    1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  noc_flit_rx_buffer_if #(.FLIT_WIDTH(FLIT_WIDTH), .DEST_WIDTH(DEST_WIDTH), .FLIT_BUFFER_DEPTH(4)) ia ();
  noc_flit_rx_buffer_if #(.FLIT_WIDTH(FLIT_WIDTH), .DEST_WIDTH(DEST_WIDTH), .FLIT_BUFFER_DEPTH(4)) ib ();

  noc_flit_rx_buffer #(.FLIT_WIDTH(FLIT_WIDTH), .DEST_WIDTH(DEST_WIDTH), .FLIT_BUFFER_DEPTH(4),
                       .STORE_AND_FORWARD(1'b0)) dut_cut (.clk(clk), .rst(rst), .bus(ia.slave));
  noc_flit_rx_buffer #(.FLIT_WIDTH(FLIT_WIDTH), .DEST_WIDTH(DEST_WIDTH), .FLIT_BUFFER_DEPTH(4),
                       .STORE_AND_FORWARD(1'b1)) dut_saf (.clk(clk), .rst(rst), .bus(ib.slave));

  int    n_checks = 0;
  int    n_fail   = 0;
  flit_t sb_a[$];
  flit_t sb_s[$];
  flit_t got;
  flit_t f;

  function automatic flit_t mk(input logic tail);
    flit_t r;
    r.data    = {$urandom(), $urandom(), $urandom(), $urandom()};
    r.dest    = DEST_WIDTH'($urandom_range(0, 63));
    r.is_tail = tail;
    return r;
  endfunction

  task automatic drv_a(input logic send, input flit_t fl, input logic ready);
    ia.send_in = send; ia.data_in = fl.data; ia.dest_in = fl.dest;
    ia.is_tail_in = fl.is_tail; ia.out_ready = ready;
  endtask

  task automatic drv_s(input logic send, input flit_t fl, input logic ready);
    ib.send_in = send; ib.data_in = fl.data; ib.dest_in = fl.dest;
    ib.is_tail_in = fl.is_tail; ib.out_ready = ready;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drv_a(1'b0, '0, 1'b0);
    drv_s(1'b0, '0, 1'b0);
    repeat (2) @(negedge clk);
    n_checks++; if (ia.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", ia.out_valid); end
    n_checks++; if (ia.occupancy !== 3'd0) begin n_fail++; $display("FAIL reset_occ: got %0d expected 0", ia.occupancy); end
    n_checks++; if (ia.credit_out !== 1'b0) begin n_fail++; $display("FAIL reset_credit: got %0b expected 0", ia.credit_out); end
    n_checks++; if (ia.err_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b expected 0", ia.err_overflow); end
    n_checks++; if (ib.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_saf_valid: got %0b expected 0", ib.out_valid); end
    n_checks++; if (ib.occupancy !== 3'd0) begin n_fail++; $display("FAIL reset_saf_occ: got %0d expected 0", ib.occupancy); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_flit;
    f = mk(1'b1);
    drv_a(1'b1, f, 1'b1); sb_a.push_back(f);
    @(negedge clk);
    got = {ia.out_data, ia.out_dest, ia.out_is_tail};
    n_checks++; if (ia.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b expected 1", ia.out_valid); end
    n_checks++; if (ia.occupancy !== 3'd1) begin n_fail++; $display("FAIL single_occ: got %0d expected 1", ia.occupancy); end
    n_checks++; if (ia.credit_out !== 1'b0) begin n_fail++; $display("FAIL single_early_credit: got %0b expected 0", ia.credit_out); end
    n_checks++; if (got !== sb_a[0]) begin n_fail++; $display("FAIL single_data: got %h expected %h", got, sb_a[0]); end
    void'(sb_a.pop_front());
    drv_a(1'b0, '0, 1'b1);
    @(negedge clk);
    n_checks++; if (ia.credit_out !== 1'b1) begin n_fail++; $display("FAIL single_credit: got %0b expected 1", ia.credit_out); end
    n_checks++; if (ia.occupancy !== 3'd0) begin n_fail++; $display("FAIL single_occ_after: got %0d expected 0", ia.occupancy); end
    n_checks++; if (ia.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_after: got %0b expected 0", ia.out_valid); end
    drv_a(1'b0, '0, 1'b0);
    @(negedge clk);
    n_checks++; if (ia.credit_out !== 1'b0) begin n_fail++; $display("FAIL single_credit_width: got %0b expected 0", ia.credit_out); end
  endtask

  task automatic test_fill_release;
    for (int i = 0; i < 4; i++) begin
      f = mk(i == 3); drv_a(1'b1, f, 1'b0); sb_a.push_back(f);
      @(negedge clk);
    end
    drv_a(1'b0, '0, 1'b0);
    got = {ia.out_data, ia.out_dest, ia.out_is_tail};
    n_checks++; if (ia.occupancy !== 3'd4) begin n_fail++; $display("FAIL fill_occ: got %0d expected 4", ia.occupancy); end
    n_checks++; if (ia.out_valid !== 1'b1) begin n_fail++; $display("FAIL fill_valid: got %0b expected 1", ia.out_valid); end
    n_checks++; if (got !== sb_a[0]) begin n_fail++; $display("FAIL fill_head: got %h expected %h", got, sb_a[0]); end
    @(negedge clk);
    got = {ia.out_data, ia.out_dest, ia.out_is_tail};
    n_checks++; if (got !== sb_a[0]) begin n_fail++; $display("FAIL fill_hold: got %h expected %h", got, sb_a[0]); end
    drv_a(1'b0, '0, 1'b1);
    void'(sb_a.pop_front());
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (ia.credit_out !== 1'b1) begin n_fail++; $display("FAIL release_credit%0d: got %0b expected 1", i, ia.credit_out); end
      if (i < 3) begin
        got = {ia.out_data, ia.out_dest, ia.out_is_tail};
        n_checks++; if (got !== sb_a[0]) begin n_fail++; $display("FAIL release_order%0d: got %h expected %h", i, got, sb_a[0]); end
        void'(sb_a.pop_front());
      end else begin
        drv_a(1'b0, '0, 1'b0);
        n_checks++; if (ia.occupancy !== 3'd0) begin n_fail++; $display("FAIL release_occ: got %0d expected 0", ia.occupancy); end
      end
    end
    @(negedge clk);
    n_checks++; if (ia.credit_out !== 1'b0) begin n_fail++; $display("FAIL release_credit_end: got %0b expected 0", ia.credit_out); end
  endtask

  task automatic test_back_to_back;
    int credits = 0;
    for (int i = 0; i < 4; i++) begin
      f = mk(1'b0); drv_a(1'b1, f, 1'b0); sb_a.push_back(f);
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      got = {ia.out_data, ia.out_dest, ia.out_is_tail};
      n_checks++; if (ia.occupancy !== 3'd4) begin n_fail++; $display("FAIL b2b_occ%0d: got %0d expected 4", i, ia.occupancy); end
      n_checks++; if (got !== sb_a[0]) begin n_fail++; $display("FAIL b2b_order%0d: got %h expected %h", i, got, sb_a[0]); end
      void'(sb_a.pop_front());
      f = mk(1'b0); drv_a(1'b1, f, 1'b1); sb_a.push_back(f);
      @(negedge clk);
      if (ia.credit_out === 1'b1) credits++;
    end
    drv_a(1'b0, '0, 1'b1);
    n_checks++; if (credits !== 8) begin n_fail++; $display("FAIL b2b_credits: got %0d expected 8", credits); end
    n_checks++; if (ia.err_overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_err: got %0b expected 0", ia.err_overflow); end
    for (int i = 0; i < 4; i++) begin
      got = {ia.out_data, ia.out_dest, ia.out_is_tail};
      n_checks++; if (got !== sb_a[0]) begin n_fail++; $display("FAIL b2b_drain%0d: got %h expected %h", i, got, sb_a[0]); end
      void'(sb_a.pop_front());
      @(negedge clk);
    end
    drv_a(1'b0, '0, 1'b0);
    n_checks++; if (ia.occupancy !== 3'd0) begin n_fail++; $display("FAIL b2b_occ_end: got %0d expected 0", ia.occupancy); end
    @(negedge clk);
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 4; i++) begin
      f = mk(1'b0); drv_a(1'b1, f, 1'b0); sb_a.push_back(f);
      @(negedge clk);
    end
    drv_a(1'b1, mk(1'b1), 1'b0);
    @(negedge clk);
    drv_a(1'b0, '0, 1'b0);
    n_checks++; if (ia.occupancy !== 3'd4) begin n_fail++; $display("FAIL ovf_occ: got %0d expected 4", ia.occupancy); end
    n_checks++; if (ia.err_overflow !== EXP_ERR) begin n_fail++; $display("FAIL ovf_err: got %0b expected %0b", ia.err_overflow, EXP_ERR); end
    repeat (2) @(negedge clk);
    drv_a(1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      got = {ia.out_data, ia.out_dest, ia.out_is_tail};
      n_checks++; if (got !== sb_a[0]) begin n_fail++; $display("FAIL ovf_order%0d: got %h expected %h", i, got, sb_a[0]); end
      void'(sb_a.pop_front());
      @(negedge clk);
    end
    drv_a(1'b0, '0, 1'b0);
    n_checks++; if (ia.out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_dropped: got %0b expected 0", ia.out_valid); end
    n_checks++; if (ia.err_overflow !== EXP_ERR) begin n_fail++; $display("FAIL ovf_sticky: got %0b expected %0b", ia.err_overflow, EXP_ERR); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (ia.err_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %0b expected 0", ia.err_overflow); end
    @(negedge clk);
  endtask

  task automatic test_reset_midop;
    for (int i = 0; i < 3; i++) begin
      drv_a(1'b1, mk(1'b0), 1'b0);
      @(negedge clk);
    end
    drv_a(1'b0, '0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drv_a(1'b0, '0, 1'b0);
    n_checks++; if (ia.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %0b expected 0", ia.out_valid); end
    n_checks++; if (ia.occupancy !== 3'd0) begin n_fail++; $display("FAIL midrst_occ: got %0d expected 0", ia.occupancy); end
    n_checks++; if (ia.credit_out !== 1'b0) begin n_fail++; $display("FAIL midrst_credit: got %0b expected 0", ia.credit_out); end
    @(negedge clk);
    n_checks++; if (ia.credit_out !== 1'b0) begin n_fail++; $display("FAIL midrst_credit2: got %0b expected 0", ia.credit_out); end
    sb_a.delete();
  endtask

  task automatic test_saf_short;
    for (int i = 0; i < 3; i++) begin
      f = mk(i == 2); drv_s(1'b1, f, 1'b0); sb_s.push_back(f);
      @(negedge clk);
      if (i < 2) begin
        n_checks++; if (ib.out_valid !== 1'b0) begin n_fail++; $display("FAIL saf_hold%0d: got %0b expected 0", i, ib.out_valid); end
      end
    end
    drv_s(1'b0, '0, 1'b1);
    n_checks++; if (ib.out_valid !== 1'b1) begin n_fail++; $display("FAIL saf_release: got %0b expected 1", ib.out_valid); end
    n_checks++; if (ib.occupancy !== 3'd3) begin n_fail++; $display("FAIL saf_occ: got %0d expected 3", ib.occupancy); end
    for (int i = 0; i < 3; i++) begin
      got = {ib.out_data, ib.out_dest, ib.out_is_tail};
      n_checks++; if (got !== sb_s[0]) begin n_fail++; $display("FAIL saf_order%0d: got %h expected %h", i, got, sb_s[0]); end
      void'(sb_s.pop_front());
      @(negedge clk);
    end
    drv_s(1'b0, '0, 1'b0);
    n_checks++; if (ib.out_valid !== 1'b0) begin n_fail++; $display("FAIL saf_empty: got %0b expected 0", ib.out_valid); end
    @(negedge clk);
  endtask

  task automatic test_saf_long;
    for (int i = 0; i < 4; i++) begin
      f = mk(1'b0); drv_s(1'b1, f, 1'b0); sb_s.push_back(f);
      @(negedge clk);
      if (i < 3) begin
        n_checks++; if (ib.out_valid !== 1'b0) begin n_fail++; $display("FAIL saflong_hold%0d: got %0b expected 0", i, ib.out_valid); end
      end else begin
        n_checks++; if (ib.out_valid !== 1'b1) begin n_fail++; $display("FAIL saflong_fallback: got %0b expected 1", ib.out_valid); end
        n_checks++; if (ib.occupancy !== 3'd4) begin n_fail++; $display("FAIL saflong_occ: got %0d expected 4", ib.occupancy); end
      end
    end
    for (int i = 0; i < 2; i++) begin
      got = {ib.out_data, ib.out_dest, ib.out_is_tail};
      n_checks++; if (ib.out_valid !== 1'b1) begin n_fail++; $display("FAIL saflong_valid%0d: got %0b expected 1", i, ib.out_valid); end
      n_checks++; if (got !== sb_s[0]) begin n_fail++; $display("FAIL saflong_order%0d: got %h expected %h", i, got, sb_s[0]); end
      void'(sb_s.pop_front());
      f = mk(i == 1); drv_s(1'b1, f, 1'b1); sb_s.push_back(f);
      @(negedge clk);
    end
    drv_s(1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      got = {ib.out_data, ib.out_dest, ib.out_is_tail};
      n_checks++; if (ib.out_valid !== 1'b1) begin n_fail++; $display("FAIL saflong_dvalid%0d: got %0b expected 1", i, ib.out_valid); end
      n_checks++; if (got !== sb_s[0]) begin n_fail++; $display("FAIL saflong_drain%0d: got %h expected %h", i, got, sb_s[0]); end
      void'(sb_s.pop_front());
      @(negedge clk);
    end
    drv_s(1'b0, '0, 1'b0);
    n_checks++; if (ib.occupancy !== 3'd0) begin n_fail++; $display("FAIL saflong_occ_end: got %0d expected 0", ib.occupancy); end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_single_flit();
    test_fill_release();
    test_back_to_back();
    test_overflow();
    test_reset_midop();
    test_saf_short();
    test_saf_long();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
